alu_issue_arbiter: RTL

//  Shares the single combinational ALU between N_REQ issue requesters. Picks
//  at most one ready request per cycle, round-robin, and drives it into the
//  ALU. Registers the ALU result together with the winner's index in a
//  one-entry output buffer for writeback.

---
 rtl/alu_issue_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares one combinational ALU between N_REQ issue requesters. Each cycle at
// most one ready request is picked round-robin and driven into the ALU. The
// ALU result is registered together with the winner's index in a one-entry
// output buffer for writeback. The buffer can drain and refill in the same
// cycle, so sustained throughput is one result per cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low (0 = reset)
//   flush       in   pipeline flush: blocks grants, empties the buffer
//   req_valid   in   [N_REQ]        requester i has an instruction
//   req_data    in   [N_REQ*DEC_W]  payload i at [i*DEC_W +: DEC_W]
//   req_ready   out  [N_REQ]        one-hot grant, payload i accepted
//   alu_valid   out                 ALU input valid
//   alu_data    out  [DEC_W]        payload of the granted requester
//   alu_ready   in                  ALU accepts this cycle
//   alu_result  in   [RES_W]        ALU combinational result for alu_data
//   wb_valid    out                 output buffer holds a result
//   wb_data     out  [RES_W]        buffered result
//   wb_tag      out  [clog2(N_REQ)] requester that produced wb_data
//   wb_ready    in                  writeback consumes wb_data this cycle
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEC_W = 128,
  parameter int RES_W = 70
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DEC_W-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     alu_valid,
  output logic [DEC_W-1:0]         alu_data,
  input  logic                     alu_ready,
  input  logic [RES_W-1:0]         alu_result,
  output logic                     wb_valid,
  output logic [RES_W-1:0]         wb_data,
  output logic [$clog2(N_REQ)-1:0] wb_tag,
  input  logic                     wb_ready
);

  localparam int TAG_W = $clog2(N_REQ);
  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [TAG_W:0] N_EXT = (TAG_W+1)'(N_REQ);

  logic [TAG_W-1:0] r_rr_ptr;
  logic             r_wb_valid;
  logic [RES_W-1:0] r_wb_data;
  logic [TAG_W-1:0] r_wb_tag;

  logic             w_can_issue;
  logic             w_found;
  logic             w_grant;
  logic [TAG_W-1:0] w_winner;
  logic [TAG_W-1:0] w_idx;
  logic [TAG_W:0]   w_sum;
  logic [TAG_W:0]   w_next_sum;
  logic [TAG_W-1:0] w_next_ptr;

  // Including rst keeps the grant outputs quiet while reset is held.
  // The buffer may accept when empty or when it is being drained this cycle.
  assign w_can_issue = rst & alu_ready & ~flush & (~r_wb_valid | wb_ready);
  assign w_grant     = w_can_issue & w_found;

  // Round-robin scan. Offsets are walked from the farthest to the nearest,
  // so the last hit is the first valid requester at or after r_rr_ptr.
  // Only req_valid feeds the grant, never req_data.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      if (w_sum >= N_EXT) begin
        w_sum = w_sum - N_EXT;
      end
      w_idx = w_sum[TAG_W-1:0];
      if (req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Pointer moves to the slot just past the winner, wrapping at N_REQ-1.
  always_comb begin
    w_next_sum = {1'b0, w_winner} + (TAG_W+1)'(1);
    w_next_ptr = w_next_sum[TAG_W-1:0];
    if (w_next_sum >= N_EXT) begin
      w_next_ptr = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    alu_valid = 1'b0;
    alu_data  = '0;
    if (w_grant) begin
      req_ready[w_winner] = 1'b1;
      alu_valid           = 1'b1;
      alu_data            = req_data[int'(w_winner)*DEC_W +: DEC_W];
    end
  end

  // A grant always refills the buffer (drain and refill in the same cycle).
  // Flush never coincides with a grant, so it only has to clear wb_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_tag   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_grant) begin
        r_rr_ptr   <= w_next_ptr;
        r_wb_valid <= 1'b1;
        r_wb_data  <= alu_result;
        r_wb_tag   <= w_winner;
      end else if (flush || wb_ready) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign wb_tag   = r_wb_tag;

endmodule
